drive_arbiter: RTL and testbench

Registered arbiter that owns the car's four motion signals (forward, backward, left, right). It sits between the three mode controllers (manual, semi-auto, auto) and the simulated-device motion inputs, replacing the plain 4:1 mode muxes. It grants the motion outputs to exactly one controller, selected by the active mode. It also enforces three safety rules: an all-stop settle window after every mode change, a stop gap before any forward/backward reversal, and suppression of forward motion while the front detector is asserted.

---
 rtl/drive_arbiter.sv | 124 ++++++++++++
 tb/tb_drive_arbiter.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/drive_arbiter.sv
// Motion-signal arbiter: grants the car's four motion outputs to the active
// mode controller, with settle, reversal-gap and front-obstacle interlocks.
module drive_arbiter #(
    parameter int SETTLE_CYCLES = 8,
    parameter int REVERSE_GAP   = 4,
    parameter int CNT_W         = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] mode,
    input  logic [3:0] man_cmd,
    input  logic [3:0] semi_cmd,
    input  logic [3:0] auto_cmd,
    input  logic [3:0] detector,
    output logic       move_forward,
    output logic       move_backward,
    output logic       turn_left,
    output logic       turn_right,
    output logic [1:0] grant,
    output logic       blocked,
    output logic       busy,
    output logic [1:0] out_state
);

    typedef enum logic [1:0] {
        OFF    = 2'b00,
        SETTLE = 2'b01,
        DRIVE  = 2'b10,
        GAP    = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD    = CNT_W'(REVERSE_GAP - 1);
    localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] count;
    logic [3:0]       req;
    logic [3:0]       san;
    logic             blk;
    logic             rev;
    logic             unused;

    assign unused    = ^detector[2:0];
    assign busy      = (state == SETTLE) || (state == GAP);
    assign out_state = state;

    // Sanitized request of the granted controller: {fwd, bwd, left, right}
    always_comb begin
        req = 4'b0000;
        case (grant)
            2'b11:   req = semi_cmd;
            2'b10:   req = auto_cmd;
            2'b01:   req = man_cmd;
            default: req = 4'b0000;
        endcase
        san = req;
        if (san[3] && san[2]) san[3:2] = 2'b00;
        if (san[1] && san[0]) san[1:0] = 2'b00;
        blk = san[3] && detector[3];
        if (blk) san[3] = 1'b0;
        rev = (move_forward && san[2]) || (move_backward && san[3]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= OFF;
            count         <= '0;
            grant         <= 2'b00;
            blocked       <= 1'b0;
            move_forward  <= 1'b0;
            move_backward <= 1'b0;
            turn_left     <= 1'b0;
            turn_right    <= 1'b0;
        end else if (mode == 2'b00) begin
            state         <= OFF;
            grant         <= 2'b00;
            blocked       <= 1'b0;
            move_forward  <= 1'b0;
            move_backward <= 1'b0;
            turn_left     <= 1'b0;
            turn_right    <= 1'b0;
        end else if (mode != grant) begin
            state         <= SETTLE;
            grant         <= mode;
            count         <= SETTLE_LOAD;
            blocked       <= 1'b0;
            move_forward  <= 1'b0;
            move_backward <= 1'b0;
            turn_left     <= 1'b0;
            turn_right    <= 1'b0;
        end else begin
            case (state)
                SETTLE, GAP: begin
                    move_forward  <= 1'b0;
                    move_backward <= 1'b0;
                    turn_left     <= 1'b0;
                    turn_right    <= 1'b0;
                    if (count == '0) state <= DRIVE;
                    else count <= count - ONE;
                end
                DRIVE: begin
                    if (rev) begin
                        state         <= GAP;
                        count         <= GAP_LOAD;
                        blocked       <= 1'b0;
                        move_forward  <= 1'b0;
                        move_backward <= 1'b0;
                        turn_left     <= 1'b0;
                        turn_right    <= 1'b0;
                    end else begin
                        blocked       <= blk;
                        move_forward  <= san[3];
                        move_backward <= san[2];
                        turn_left     <= san[1];
                        turn_right    <= san[0];
                    end
                end
                default: state <= OFF;
            endcase
        end
    end

endmodule

// File: tb/tb_drive_arbiter.sv
// Directed bench for drive_arbiter: settle, conflicts, reversal gap,
// front blocking, mid-window mode changes and reset.
module tb_drive_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] mode;
    logic [3:0] man_cmd, semi_cmd, auto_cmd, detector;
    logic       move_forward, move_backward, turn_left, turn_right;
    logic [1:0] grant, out_state;
    logic       blocked, busy;

    int total = 0;
    int passed = 0;

    localparam logic [1:0] S_OFF = 2'b00, S_SET = 2'b01;
    localparam logic [1:0] S_DRV = 2'b10, S_GAP = 2'b11;

    drive_arbiter dut (
        .clk(clk), .reset(reset), .mode(mode),
        .man_cmd(man_cmd), .semi_cmd(semi_cmd), .auto_cmd(auto_cmd),
        .detector(detector),
        .move_forward(move_forward), .move_backward(move_backward),
        .turn_left(turn_left), .turn_right(turn_right),
        .grant(grant), .blocked(blocked), .busy(busy),
        .out_state(out_state)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] motion();
        return {move_forward, move_backward, turn_left, turn_right};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Mode was applied before this call; runs SETTLE entry + window
    // and checks busy throughout, ending with state DRIVE.
    task automatic settle(input string tag);
        for (int i = 0; i < 8; i++) begin
            step();
            chk({tag, "_mot0"}, motion(), 4'b0000);
            chk({tag, "_busy"}, busy, 1'b1);
        end
        step();
        chk({tag, "_drv"}, out_state, S_DRV);
        chk({tag, "_drvmot"}, motion(), 4'b0000);
    endtask

    initial begin
        reset = 1'b1; mode = 2'b00;
        man_cmd = '0; semi_cmd = '0; auto_cmd = '0; detector = '0;
        step(); step();
        reset = 1'b0;
        chk("rst_mot", motion(), 4'b0000);
        chk("rst_state", out_state, S_OFF);
        chk("rst_grant", grant, 2'b00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_blk", blocked, 1'b0);

        // OFF -> manual
        mode = 2'b01; man_cmd = 4'b1000;
        settle("man");
        step();
        chk("man_fwd", motion(), 4'b1000);
        chk("man_grant", grant, 2'b01);

        // conflicting pairs
        man_cmd = 4'b1100; step();
        chk("conf_fb", motion(), 4'b0000);
        man_cmd = 4'b0011; step();
        chk("conf_lr", motion(), 4'b0000);
        chk("conf_state", out_state, S_DRV);

        // reversal gap
        man_cmd = 4'b1000; step();
        chk("rev_pre", motion(), 4'b1000);
        man_cmd = 4'b0100;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("rev_mot0", motion(), 4'b0000);
            chk("rev_state", out_state, (i < 4) ? S_GAP : S_DRV);
        end
        step();
        chk("rev_bwd", motion(), 4'b0100);

        // auto with front detector
        mode = 2'b10; auto_cmd = 4'b1010; detector = 4'b1000;
        step();
        chk("auto_modechg", motion(), 4'b0000);
        chk("auto_grant", grant, 2'b10);
        for (int i = 0; i < 7; i++) step();
        step();
        chk("auto_drv", out_state, S_DRV);
        step();
        chk("blk_mot", motion(), 4'b0010);
        chk("blk_flag", blocked, 1'b1);
        detector = 4'b0000; step();
        chk("unblk_mot", motion(), 4'b1010);
        chk("unblk_flag", blocked, 1'b0);
        man_cmd = 4'b0001; step();
        chk("ignore_man", motion(), 4'b1010);

        // semi forward, then mode change mid-SETTLE restarts window
        mode = 2'b11; semi_cmd = 4'b1000;
        settle("semi");
        step();
        chk("semi_fwd", motion(), 4'b1000);
        mode = 2'b10; step();
        chk("sw10_grant", grant, 2'b10);
        chk("sw10_mot", motion(), 4'b0000);
        for (int i = 0; i < 4; i++) step();
        chk("sw10_mid", out_state, S_SET);
        mode = 2'b11; step();
        chk("sw11_grant", grant, 2'b11);
        for (int i = 0; i < 7; i++) begin
            step();
            chk("sw11_busy", busy, 1'b1);
        end
        step();
        chk("sw11_drv", out_state, S_DRV);
        mode = 2'b10; step(); step(); step();
        chk("abort_pre", out_state, S_SET);
        mode = 2'b00; step();
        chk("abort_state", out_state, S_OFF);
        chk("abort_grant", grant, 2'b00);
        chk("abort_mot", motion(), 4'b0000);

        // reset mid-GAP
        mode = 2'b01; man_cmd = 4'b1000;
        settle("man2");
        step();
        chk("man2_fwd", motion(), 4'b1000);
        man_cmd = 4'b0100; step(); step();
        chk("gap_state", out_state, S_GAP);
        reset = 1'b1; man_cmd = 4'b1000; step();
        reset = 1'b0;
        chk("rgap_state", out_state, S_OFF);
        chk("rgap_mot", motion(), 4'b0000);
        chk("rgap_grant", grant, 2'b00);
        settle("man3");
        step();
        chk("man3_fwd", motion(), 4'b1000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
